// File: rtl/kpscan.sv
// kpscan: 4x4 keypad column scanner with press/release debounce and one-cycle key events.
// The release event leaves on release_o because release is a reserved word.
module kpscan #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] kpr,
    output logic [3:0] kpc,
    output logic [1:0] row_idx,
    output logic [1:0] col_idx,
    output logic       press,
    output logic       release_o,
    output logic       held
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(DEBOUNCE_CYC);
    typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, RELEASE_DB} state_t;
    state_t state_q, state_d;
    logic [3:0] kpr_m_q, kpr_s_q, kpc_q, kpc_d, pat_q, pat_d;
    logic [DW-1:0] div_q, div_d;
    logic [BW-1:0] db_q, db_d;
    logic [1:0] row_q, row_d, col_q, col_d;
    logic press_q, press_d, rel_q, rel_d, held_q, held_d;
    logic idle, div_end, db_end, adv;
    assign idle    = kpr_s_q == 4'hF;
    assign div_end = div_q == DW'(SCAN_DIV - 1);
    assign db_end  = db_q == BW'(DEBOUNCE_CYC - 1);
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        db_d    = db_q;
        pat_d   = pat_q;
        row_d   = row_q;
        held_d  = held_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        adv     = 1'b0;
        case (state_q)
            SCAN:
                if (!div_end) div_d = div_q + 1'b1;
                else if (idle) begin
                    adv   = 1'b1;
                    div_d = '0;
                end else begin
                    pat_d   = kpr_s_q;
                    db_d    = '0;
                    state_d = PRESS_DB;
                end
            PRESS_DB:
                if (kpr_s_q != pat_q) begin
                    div_d   = '0;
                    state_d = SCAN;
                end else if (!db_end) db_d = db_q + 1'b1;
                else begin
                    state_d = HELD;
                    // multi-key patterns fall through to HELD as a silent lockout
                    if ($countones(~pat_q) == 1) begin
                        press_d = 1'b1;
                        held_d  = 1'b1;
                        row_d   = !pat_q[3] ? 2'd3 : !pat_q[2] ? 2'd2 : !pat_q[1] ? 2'd1 : 2'd0;
                    end
                end
            HELD:
                if (idle) begin
                    db_d    = '0;
                    state_d = RELEASE_DB;
                end
            RELEASE_DB:
                if (!idle) state_d = HELD;
                else if (!db_end) db_d = db_q + 1'b1;
                else begin
                    rel_d   = held_q;
                    held_d  = 1'b0;
                    adv     = 1'b1;
                    div_d   = '0;
                    state_d = SCAN;
                end
        endcase
        kpc_d = adv ? {kpc_q[0], kpc_q[3:1]} : kpc_q;
        col_d = adv ? col_q - 1'b1 : col_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kpr_m_q <= 4'hF;
            kpr_s_q <= 4'hF;
            state_q <= SCAN;
            div_q   <= '0;
            db_q    <= '0;
            pat_q   <= 4'hF;
            kpc_q   <= 4'b0111;
            row_q   <= 2'd0;
            col_q   <= 2'd3;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            kpr_m_q <= kpr;
            kpr_s_q <= kpr_m_q;
            state_q <= state_d;
            div_q   <= div_d;
            db_q    <= db_d;
            pat_q   <= pat_d;
            kpc_q   <= kpc_d;
            row_q   <= row_d;
            col_q   <= col_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            held_q  <= held_d;
        end
    end
    assign kpc       = kpc_q;
    assign row_idx   = row_q;
    assign col_idx   = col_q;
    assign press     = press_q;
    assign release_o = rel_q;
    assign held      = held_q;
endmodule

// File: doc/kpscan.md
Name: kpscan

Overview:
- Keypad column scanner and debouncer for the 4x4 matrix keypad; the drive side of the keypad interface.
- Drives the active-low column lines `kpc` one column at a time and samples the active-low row lines `kpr`.
- Freezes the scan on a press and debounces both press and release.
- Publishes `kpc` to the downstream key decoder, plus a clean row/column index and single-cycle press/release events for the control logic.

Parameters:
- SCAN_DIV, 50000: clk cycles each column is driven before `kpr` is sampled (1 kHz column step at 50 MHz). Must be >= 4.
- DEBOUNCE_CYC, 500000: consecutive stable clk cycles required to accept a press or a release (10 ms at 50 MHz). Must be >= 2.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- kpr  input  4  keypad row lines, active-low, asynchronous to clk (pull-ups, 1111 = no key)
- kpc  output  4  keypad column drive, active-low one-cold; also feeds the key decoder
- row_idx  output  2  row of the accepted key (kpr 0111→3, 1011→2, 1101→1, 1110→0)
- col_idx  output  2  column of the accepted key (index of the low bit of kpc)
- press  output  1  one-cycle pulse when a single-key press is accepted
- release  output  1  one-cycle pulse when that key's release is accepted
- held  output  1  high from the press pulse until the cycle of the release pulse

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. All flops are reset asynchronously.
- Reset values: kpc=0111, row_idx=0, col_idx=3, press=0, release=0, held=0, state=SCAN, counters=0, synchroniser=1111.
- Reset asserted mid-operation aborts immediately to these values. No press/release pulse is emitted.
- Synchroniser: kpr passes through 2 flops (kpr_s) before any use. All decisions use kpr_s.
- Column order: kpc rotates right, 0111→1011→1101→1110→0111. col_idx tracks the low bit.
- All outputs are registered.
- State SCAN:
  - div counts 0..SCAN_DIV-1 on the current column.
  - At div==SCAN_DIV-1: if kpr_s==1111, advance the column and reset div.
  - Otherwise capture pat=kpr_s, clear db, and go to PRESS_DB. kpc is held.
- State PRESS_DB:
  - kpc is held.
  - If kpr_s!=pat: go to SCAN, div=0, same column (rescan).
  - Else db increments. When DEBOUNCE_CYC consecutive matching samples are reached:
    - If pat has exactly one zero bit: latch row_idx from pat, pulse press for 1 cycle, set held=1, go to HELD.
    - If pat has two or more zeros (multi-key): no press, held stays 0, go to HELD (lockout).
- State HELD:
  - kpc is held.
  - When kpr_s==1111: clear db, go to RELEASE_DB.
- State RELEASE_DB:
  - If kpr_s!=1111: go back to HELD with no pulse.
  - After DEBOUNCE_CYC consecutive 1111 samples:
    - If held=1: pulse release for 1 cycle and clear held in that same cycle.
    - Go to SCAN with div=0 and the column advanced to the next one.
- Latency:
  - The press pulse occurs on the cycle after the DEBOUNCE_CYC-th stable sample in PRESS_DB.
  - Release is measured the same way in RELEASE_DB.
  - kpr to kpr_s adds 2 cycles.
- Outputs stable between pulses: row_idx and col_idx change only on an accepted press (col_idx also tracks kpc while scanning). Both are valid whenever held=1.
- press and release are never high in the same cycle. press never repeats while a key stays down (no auto-repeat).
- Counter widths: sized with $clog2 of each parameter. No wrap-around is possible, because each counter is cleared on every state entry.

Test Plan (SCAN_DIV=4, DEBOUNCE_CYC=8, bench keypad model drives kpr from kpc combinationally):
- Idle scan, no key → kpc steps 0111,1011,1101,1110,0111, each held exactly 4 cycles. press/release/held stay 0.
- Clean press of the key at col 1 / row 2 (kpr=1011 while kpc=1101), held 40 cycles then released:
  - kpc freezes at 1101.
  - press is high exactly 1 cycle; row_idx=2, col_idx=1; held=1.
  - After release: release pulses once 8 stable cycles later, held→0, and the next kpc is 1110.
- Bouncy press: kpr toggles 1011/1111 every 3 cycles for 30 cycles, then stays 1011 → exactly one press pulse, issued 8 stable cycles after the bounce ends.
- Two keys in the same column (kpr=0011) → no press pulse, held=0, kpc frozen; after release + 8 cycles, scanning resumes with no release pulse.
- Release glitch: a key is held; kpr goes 1111 for 5 cycles, back to 1011, then 1111 → no release pulse from the glitch; exactly one release pulse 8 cycles after the final 1111.
- Reset asserted 3 cycles into PRESS_DB → all outputs return to their reset values asynchronously, kpc=0111, and no press pulse follows deassertion while kpr=1111.
